// File: rtl/arith_share_ctrl.sv
// Two-requester round-robin front end for a shared 4-bit ArithOp datapath.
// One operation in flight at a time: IDLE accepts, EXEC computes, RESP waits for the consumer.

module arith_op (
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    output logic [3:0] res1,
    output logic [3:0] res2,
    output logic [3:0] res3,
    output logic [3:0] res4,
    output logic [3:0] res5
);
    // A zero divisor is replaced by 1 so the divider never produces X.
    // The controller discards that result and reports an error instead.
    logic [3:0] den;
    assign den  = (in2 == 4'd0) ? 4'd1 : in2;
    assign res1 = in1 + in2;
    assign res2 = in1 - in2;
    assign res3 = in1 * in2;
    assign res4 = in1 / den;
    assign res5 = in1 % den;
endmodule

module arith_share_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [3:0]       rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Request ready is combinational and only ever high in IDLE; rsp_valid
    // is high for the whole of RESP and the payload is frozen until rsp_ready.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic       ptr;
    logic [2:0] op_r;
    logic [3:0] a_r, b_r;
    logic       id_r;
    logic       grant0, grant1;
    logic [3:0] res1, res2, res3, res4, res5;
    logic [3:0] res_data;
    logic       res_err;

    // Pointer names the requester that wins when both are valid.
    assign grant0 = req0_valid && (!req1_valid || !ptr);
    assign grant1 = req1_valid && (!req0_valid ||  ptr);

    arith_op u_arith (
        .in1  (a_r),
        .in2  (b_r),
        .res1 (res1),
        .res2 (res2),
        .res3 (res3),
        .res4 (res4),
        .res5 (res5)
    );

    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) state_nx = EXEC;
            end
            EXEC: state_nx = RESP;
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        res_data = 4'd0;
        res_err  = 1'b0;
        case (op_r)
            3'd0: res_data = res1;
            3'd1: res_data = res2;
            3'd2: res_data = res3;
            3'd3: if (b_r == 4'd0) res_err = 1'b1; else res_data = res4;
            3'd4: if (b_r == 4'd0) res_err = 1'b1; else res_data = res5;
            default: res_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            op_r     <= 3'd0;
            a_r      <= 4'd0;
            b_r      <= 4'd0;
            id_r     <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_data <= 4'd0;
            rsp_err  <= 1'b0;
            op_count <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (grant0 || grant1)) begin
                op_r <= grant1 ? req1_op : req0_op;
                a_r  <= grant1 ? req1_a  : req0_a;
                b_r  <= grant1 ? req1_b  : req0_b;
                id_r <= grant1;
                ptr  <= !grant1;
            end
            if (state == EXEC) begin
                rsp_data <= res_data;
                rsp_err  <= res_err;
                rsp_id   <= id_r;
            end
            if (state == RESP && rsp_ready) op_count <= op_count + 1'b1;
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_arith_share_ctrl.sv
// Directed bench for arith_share_ctrl: drivers push hand-computed responses
// into a queue, a negedge monitor pops and compares on each response handshake.

module tb_arith_share_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
    logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
    logic       rsp_valid, rsp_ready = 1'b1;
    logic       rsp_id, rsp_err;
    logic [3:0] rsp_data;
    logic       busy;
    logic [7:0] op_count;

    // Expected response entry: {id, err, data}
    logic [5:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int n_hs = 0;
    int acc0 = 0, acc1 = 0;

    arith_share_ctrl #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Acceptance counters, sampled on the active edge.
    always @(posedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready) acc0++;
            if (req1_valid && req1_ready) acc1++;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst) begin
            n_hs = 0;
        end else begin
            check("op_count", int'(op_count), n_hs % 256);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    logic [5:0] e;
                    e = exp_q.pop_front();
                    check("rsp_id", int'(rsp_id), int'(e[5]));
                    check("rsp_err", int'(rsp_err), int'(e[4]));
                    check("rsp_data", int'(rsp_data), int'(e[3:0]));
                end
                n_hs++;
            end
        end
    end

    task automatic wait_acc(input int target, input string name);
        int n;
        n = 0;
        while ((acc0 + acc1) < target && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if ((acc0 + acc1) < target) check(name, 0, 1);
    endtask

    task automatic issue(input int r, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [5:0] exp);
        int start;
        start = acc0 + acc1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (r == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        #1;
        if (!busy) begin
            check("ready_granted", int'(r == 0 ? req0_ready : req1_ready), 1);
            check("ready_other", int'(r == 0 ? req1_ready : req0_ready), 0);
        end
        wait_acc(start + 1, "accept_timeout");
        if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", int'(exp_q.size() != 0 || busy), 0);
    endtask

    initial begin
        int start;
        int n;
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_data", int'(rsp_data), 0);
        check("rst_rsp_id", int'(rsp_id), 0);
        check("rst_rsp_err", int'(rsp_err), 0);
        check("rst_op_count", int'(op_count), 0);
        check("rst_ready", int'(req0_ready | req1_ready), 0);
        rst = 1'b0;

        // Single add: 5+3 = 8
        issue(0, 3'd0, 4'd5, 4'd3, {1'b0, 1'b0, 4'd8});
        drain();

        // Both valid: pointer now names requester 1, so grants go 1,0,1,0
        exp_q.push_back({1'b1, 1'b0, 4'd14});
        exp_q.push_back({1'b0, 1'b0, 4'd14});
        exp_q.push_back({1'b1, 1'b0, 4'd14});
        exp_q.push_back({1'b0, 1'b0, 4'd14});
        start = acc0 + acc1;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 4'd7; req0_b = 4'd2;
        req1_valid = 1'b1; req1_op = 3'd1; req1_a = 4'd5; req1_b = 4'd7;
        #1;
        check("both_ready0", int'(req0_ready), 0);
        check("both_ready1", int'(req1_ready), 1);
        wait_acc(start + 4, "alt_timeout");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
        check("alt_acc0", acc0, 3);
        check("alt_acc1", acc1, 2);

        // Division / modulo, including zero divisor
        issue(1, 3'd3, 4'd8, 4'd0, {1'b1, 1'b1, 4'd0});
        issue(1, 3'd4, 4'd8, 4'd0, {1'b1, 1'b1, 4'd0});
        issue(1, 3'd3, 4'd9, 4'd1, {1'b1, 1'b0, 4'd9});
        issue(1, 3'd4, 4'd9, 4'd2, {1'b1, 1'b0, 4'd1});
        drain();

        // Illegal opcode, then wrapping multiply 7*3 = 21 -> 5
        issue(0, 3'd6, 4'd3, 4'd3, {1'b0, 1'b1, 4'd0});
        issue(0, 3'd2, 4'd7, 4'd3, {1'b0, 1'b0, 4'd5});
        drain();

        // Back-pressure: response held while requester 1 waits
        rsp_ready = 1'b0;
        issue(0, 3'd0, 4'd2, 4'd2, {1'b0, 1'b0, 4'd4});
        exp_q.push_back({1'b1, 1'b0, 4'd2});
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 4'd1; req1_b = 4'd1;
        start = acc0 + acc1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        check("stall_rsp_valid", int'(rsp_valid), 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", int'(rsp_valid), 1);
            check("stall_data", int'(rsp_data), 4);
            check("stall_id", int'(rsp_id), 0);
            check("stall_err", int'(rsp_err), 0);
            check("stall_busy", int'(busy), 1);
            check("stall_req1_ready", int'(req1_ready), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_stall_busy", int'(busy), 0);
        check("post_stall_req1_ready", int'(req1_ready), 1);
        @(posedge clk);
        #1;
        check("post_stall_accept", acc0 + acc1, start + 1);
        req1_valid = 1'b0;
        drain();

        // Reset while an add is in EXEC: no response, pointer back to 0
        start = acc0 + acc1;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'd4; req0_b = 4'd4;
        wait_acc(start + 1, "rst_accept_timeout");
        req0_valid = 1'b0;
        check("exec_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_rsp_valid", int'(rsp_valid), 0);
        check("mid_rst_rsp_data", int'(rsp_data), 0);
        check("mid_rst_rsp_id", int'(rsp_id), 0);
        check("mid_rst_op_count", int'(op_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_idle", int'(busy | rsp_valid), 0);

        exp_q.push_back({1'b0, 1'b0, 4'd3});
        exp_q.push_back({1'b1, 1'b0, 4'd6});
        start = acc0 + acc1;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'd1; req0_b = 4'd2;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 4'd3; req1_b = 4'd3;
        #1;
        check("ptr_reset_ready0", int'(req0_ready), 1);
        check("ptr_reset_ready1", int'(req1_ready), 0);
        wait_acc(start + 2, "final_timeout");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
        check("final_op_count", int'(op_count), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
